syn_fifo_reader: RTL and testbench
==================================

# syn_fifo_reader

Read-side drain engine for the team's synchronous FIFO. Issues `r_en` pulses to the FIFO, captures the FIFO's registered `data_out` one cycle later, and presents words downstream on a valid/ready stream through a 2-entry skid buffer. Sustains one word per cycle with no bubbles while the FIFO is non-empty and the consumer is ready. Sits between the FIFO's read port and any stream consumer, such as a UART TX or a bus master.

## Interface
- `data_width`, 8, word width; matches the FIFO's `data_width`.
- `cnt_width`, 16, width of the transfer counter.

- `clk` in 1: single clock; all state is updated on the rising edge.
- `clr` in 1: reset, asynchronous, active-high. Shares the FIFO's reset net.
- `fifo_empty` in 1: the FIFO's `empty` output.
- `fifo_data` in `data_width`: the FIFO's `data_out`. It is valid in the cycle after an accepted `r_en`.
- `fifo_r_en` out 1: read request to the FIFO. Combinational.
- `m_valid` out 1: downstream word valid. Registered.
- `m_ready` in 1: downstream accept.
- `m_data` out `data_width`: downstream word. Registered; this is the head of the skid buffer.
- `xfer_cnt` out `cnt_width`: count of words accepted downstream. See Configuration.

## Operation
- Internal state:
  - `occ`, 0..2: skid-buffer entries held.
  - `rd_pend`: a read was issued last cycle.
  - `buf0`: head entry, drives `m_data`.
  - `buf1`: second entry.
- `m_valid = (occ != 0)`.
- `pop = m_valid & m_ready`.
- `fifo_r_en = !fifo_empty & ((occ + rd_pend - pop) < 2)`.
  - `fifo_r_en` is never asserted while `fifo_empty` is high.
  - The path from `m_ready` to `fifo_r_en` is combinational by design.
- Every edge: `rd_pend <= fifo_r_en`.
- Capture: when `rd_pend` is 1, write `fifo_data` into the first free slot after any pop is applied.
- Buffer state transitions (occ):
  - 0 to 1: capture.
  - 1 to 0: pop with no capture.
  - 1 to 1: pop and capture together; `buf0 <= fifo_data`.
  - 1 to 2: capture with no pop; write `buf1`.
  - 2 to 1: pop; `buf0 <= buf1`.
  - 2 with a capture and no pop cannot occur; the credit rule forbids it.
- Order is preserved: words leave in the order they were read.
- While `m_valid` is high and `m_ready` is low, `m_data` and `m_valid` hold stable.

## Timing
- Reset values, applied asynchronously on `clr`:
  - `occ=0`, `rd_pend=0`.
  - `m_valid=0`, `m_data=0`, `buf1=0`.
  - `xfer_cnt=0`.
  - `fifo_r_en` is 0 while the FIFO reports empty.
- Latency, starting idle: `fifo_empty` falls in cycle N.
  - `fifo_r_en` goes high in cycle N.
  - `fifo_data` is valid and `rd_pend=1` in cycle N+1.
  - `m_valid=1` in cycle N+2.
- Throughput: with `m_ready` held high and the FIFO non-empty, one word transfers per cycle.
- Backpressure: `m_ready` low for K cycles.
  - At most 2 words are held: 1 in flight plus 1 buffered, or 2 buffered.
  - No further `fifo_r_en` is issued.
  - No word is lost or duplicated.
- FIFO goes empty mid-stream: `fifo_r_en` drops in the same cycle. Already-held words still drain.
- Simultaneous pop and capture with `occ=1`: `m_valid` stays high and `m_data` advances to the next word.
- Reset mid-operation: in-flight and buffered words are discarded. The FIFO is cleared by the same `clr`, so no resynchronisation is needed.
- `xfer_cnt` increments on every `pop` and wraps modulo 2^`cnt_width`.

## Configuration
- `SYN_FIFO_READER_CNT_EN` defined: `xfer_cnt` is a live counter, implemented as described in Timing.
- Not defined: the counter register is not built, and `xfer_cnt` is tied to 0. The port list is unchanged.

## Test plan
- Reset:
  - Stimulus: assert `clr` asynchronously between edges, with words buffered and a read in flight.
  - Required: `m_valid=0`, `m_data=0`, `xfer_cnt=0`, and `fifo_r_en=0` immediately.
- Streaming:
  - Stimulus: preload the FIFO (depth 8) with 0x11..0x18; hold `m_ready=1`.
  - Required: `m_valid` rises 2 cycles after `fifo_empty` falls. Then 8 consecutive beats 0x11..0x18 with no gaps. With `_EN` defined, `xfer_cnt=8`.
- Backpressure:
  - Stimulus: preload 0xA0..0xA7; hold `m_ready=0` for 10 cycles, then release.
  - Required: exactly 2 `fifo_r_en` pulses occur before the stall. `m_data` holds 0xA0 throughout the stall. After release, the output is 0xA0..0xA7 in order with no duplicates.
- Random `m_ready`:
  - Stimulus: concurrent FIFO writes of an incrementing pattern, 1000 words, random `m_ready`.
  - Required:
    - the scoreboard matches order and values exactly;
    - `fifo_r_en` is never high while `fifo_empty` is high;
    - `occ` never exceeds 2.
- Empty boundary:
  - Stimulus: write a single word 0x5A into an empty FIFO with `m_ready=1`.
  - Required: exactly one `fifo_r_en` pulse, one beat of 0x5A, then `m_valid=0`.
- Counter wrap (`cnt_width=4`, `_EN` defined):
  - Stimulus: 17 transfers.
  - Required: `xfer_cnt=1`. Built without `_EN`, `xfer_cnt` stays 0 throughout.

Source files
------------

// File: rtl/syn_fifo_reader.sv
// syn_fifo_reader: drains a registered-output FIFO into a valid/ready stream through a 2-entry skid buffer.
// Define SYN_FIFO_READER_CNT_EN to build the live xfer_cnt counter; otherwise xfer_cnt is tied to 0.
module syn_fifo_reader #(
    parameter int data_width = 8,
    parameter int cnt_width = 16
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic                  fifo_empty,
    input  logic [data_width-1:0] fifo_data,
    output logic                  fifo_r_en,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [data_width-1:0] m_data,
    output logic [cnt_width-1:0]  xfer_cnt
);
    logic [1:0] occ, occ_n, slot;
    logic rd_pend, pop;
    logic [2:0] fill;
    logic [data_width-1:0] buf1, buf0_n, buf1_n;
    assign m_valid = occ != 2'd0;
    assign pop = m_valid & m_ready;
    assign fill = {1'b0, occ} + {2'b0, rd_pend};
    // Credit: held plus in-flight words, net of this cycle's pop, must leave room for one more.
    assign fifo_r_en = !fifo_empty && (fill < 3'd2 + {2'b0, pop});
    always_comb begin
        slot = occ - {1'b0, pop};
        occ_n = slot + {1'b0, rd_pend};
        buf0_n = (rd_pend && slot == 2'd0) ? fifo_data : pop ? buf1 : m_data;
        buf1_n = (rd_pend && slot != 2'd0) ? fifo_data : buf1;
    end
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            occ <= 2'd0;
            rd_pend <= 1'b0;
            m_data <= '0;
            buf1 <= '0;
        end else begin
            occ <= occ_n;
            rd_pend <= fifo_r_en;
            m_data <= buf0_n;
            buf1 <= buf1_n;
        end
    end
`ifdef SYN_FIFO_READER_CNT_EN
    always_ff @(posedge clk or posedge clr) begin
        if (clr)
            xfer_cnt <= '0;
        else if (pop)
            xfer_cnt <= xfer_cnt + cnt_width'(1);
    end
`else
    assign xfer_cnt = '0;
`endif
endmodule

// File: tb/tb_syn_fifo_reader.sv
// tb_syn_fifo_reader: randomized and directed checks of syn_fifo_reader against a queue-based FIFO/stream model.
module tb_syn_fifo_reader;
    localparam int DW = 8;
    localparam int CW = 4;
    logic clk = 0, clr = 1, m_ready = 0;
    logic fifo_empty, fifo_r_en, m_valid;
    logic [DW-1:0] fifo_data, m_data;
    logic [CW-1:0] xfer_cnt;
    logic [DW-1:0] mem [0:4095];
    int wptr = 0, rptr;
    int n_vec = 0, n_err = 0;
    logic [DW-1:0] exp_q[$];
    int held, cnt_model;
    logic s_valid, s_ren, s_empty, s_beat, s_bad;
    logic [DW-1:0] s_data, s_exp;
    logic [CW-1:0] s_cnt, exp_cnt;

    syn_fifo_reader #(.data_width(DW), .cnt_width(CW)) dut (
        .clk(clk), .clr(clr), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
        .fifo_r_en(fifo_r_en), .m_valid(m_valid), .m_ready(m_ready),
        .m_data(m_data), .xfer_cnt(xfer_cnt)
    );

    always #5 clk = ~clk;

    // Behavioural FIFO: registered data_out, cleared by the shared clr.
    assign fifo_empty = (wptr == rptr);
    always @(posedge clk or posedge clr) begin
        if (clr) begin
            rptr <= 0;
            fifo_data <= '0;
        end else if (fifo_r_en) begin
            fifo_data <= mem[rptr];
            rptr <= rptr + 1;
        end
    end

    task automatic model_clear();
        exp_q.delete();
        held = 0;
        cnt_model = 0;
    endtask

    task automatic push(input logic [DW-1:0] w);
        mem[wptr] = w;
        wptr = wptr + 1;
        exp_q.push_back(w);
    endtask

    // Drive m_ready just after a negedge, sample 1 ns later, advance the model, end on the next negedge.
    task automatic cycle(input logic rdy);
        m_ready = rdy;
        #1;
        s_valid = m_valid;
        s_data = m_data;
        s_ren = fifo_r_en;
        s_empty = fifo_empty;
        s_cnt = xfer_cnt;
        s_beat = m_valid && rdy;
`ifdef SYN_FIFO_READER_CNT_EN
        exp_cnt = CW'(cnt_model % (1 << CW));
`else
        exp_cnt = '0;
`endif
        s_bad = 0;
        s_exp = '0;
        if (s_beat) begin
            cnt_model++;
            if (exp_q.size() == 0) s_bad = 1;
            else s_exp = exp_q.pop_front();
        end
        held = held + int'(s_ren) - int'(s_beat);
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_vec++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b expected 0", m_valid); end
        n_vec++; if (m_data !== '0) begin n_err++; $display("FAIL reset_data: got %h expected 00", m_data); end
        n_vec++; if (xfer_cnt !== '0) begin n_err++; $display("FAIL reset_cnt: got %0d expected 0", xfer_cnt); end
        n_vec++; if (fifo_r_en !== 1'b0) begin n_err++; $display("FAIL reset_ren: got %b expected 0", fifo_r_en); end
        clr = 0;
        model_clear();
        push(8'h31); push(8'h32); push(8'h33);
        cycle(0);
        cycle(0);
        n_vec++; if (m_valid !== 1'b1) begin n_err++; $display("FAIL pre_reset_valid: got %b expected 1", m_valid); end
        #3 clr = 1;
        wptr = 0;
        model_clear();
        #1;
        n_vec++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL async_reset_valid: got %b expected 0", m_valid); end
        n_vec++; if (m_data !== '0) begin n_err++; $display("FAIL async_reset_data: got %h expected 00", m_data); end
        n_vec++; if (xfer_cnt !== '0) begin n_err++; $display("FAIL async_reset_cnt: got %0d expected 0", xfer_cnt); end
        n_vec++; if (fifo_r_en !== 1'b0) begin n_err++; $display("FAIL async_reset_ren: got %b expected 0", fifo_r_en); end
        @(negedge clk);
        clr = 0;
        cycle(1);
        n_vec++; if (s_valid !== 1'b0 || s_ren !== 1'b0) begin n_err++; $display("FAIL post_reset_idle: got valid=%b ren=%b expected 0 0", s_valid, s_ren); end
    endtask

    task automatic test_streaming();
        for (int i = 0; i < 8; i++) push(8'h11 + 8'(i));
        cycle(1);
        n_vec++; if (s_empty !== 1'b0 || s_ren !== 1'b1 || s_valid !== 1'b0) begin n_err++; $display("FAIL stream_n: got empty=%b ren=%b valid=%b expected 0 1 0", s_empty, s_ren, s_valid); end
        cycle(1);
        n_vec++; if (s_valid !== 1'b0) begin n_err++; $display("FAIL stream_n1_valid: got %b expected 0", s_valid); end
        cycle(1);
        n_vec++; if (s_valid !== 1'b1) begin n_err++; $display("FAIL stream_n2_valid: got %b expected 1", s_valid); end
        for (int i = 0; i < 8; i++) begin
            if (i > 0) cycle(1);
            n_vec++;
            if (s_beat !== 1'b1 || s_bad || s_data !== 8'h11 + 8'(i) || s_data !== s_exp) begin
                n_err++; $display("FAIL stream_beat%0d: got beat=%b data=%h expected 1 %h", i, s_beat, s_data, 8'h11 + 8'(i));
            end
        end
        cycle(1);
        n_vec++; if (s_valid !== 1'b0) begin n_err++; $display("FAIL stream_drained: got valid=%b expected 0", s_valid); end
        n_vec++; if (s_cnt !== exp_cnt) begin n_err++; $display("FAIL stream_cnt: got %0d expected %0d", s_cnt, exp_cnt); end
    endtask

    task automatic test_backpressure();
        int rens = 0, beats = 0;
        for (int i = 0; i < 8; i++) push(8'hA0 + 8'(i));
        for (int i = 0; i < 10; i++) begin
            cycle(0);
            rens += int'(s_ren);
            if (s_valid) begin
                n_vec++; if (s_data !== 8'hA0) begin n_err++; $display("FAIL stall_hold: got %h expected a0", s_data); end
            end
        end
        n_vec++; if (rens != 2) begin n_err++; $display("FAIL stall_reads: got %0d expected 2", rens); end
        n_vec++; if (held != 2) begin n_err++; $display("FAIL stall_held: got %0d expected 2", held); end
        for (int c = 0; c < 30 && beats < 8; c++) begin
            cycle(1);
            if (s_beat) begin
                n_vec++;
                if (s_bad || s_data !== 8'hA0 + 8'(beats)) begin n_err++; $display("FAIL bp_beat%0d: got %h expected %h", beats, s_data, 8'hA0 + 8'(beats)); end
                beats++;
            end
        end
        cycle(1);
        n_vec++; if (beats != 8 || exp_q.size() != 0 || s_valid !== 1'b0) begin n_err++; $display("FAIL bp_drain: got beats=%0d left=%0d valid=%b expected 8 0 0", beats, exp_q.size(), s_valid); end
    endtask

    task automatic test_empty_boundary();
        int rens = 0, beats = 0;
        push(8'h5A);
        for (int i = 0; i < 6; i++) begin
            cycle(1);
            rens += int'(s_ren);
            if (s_beat) begin
                beats++;
                n_vec++; if (s_bad || s_data !== 8'h5A) begin n_err++; $display("FAIL single_data: got %h expected 5a", s_data); end
            end
        end
        n_vec++; if (rens != 1) begin n_err++; $display("FAIL single_reads: got %0d expected 1", rens); end
        n_vec++; if (beats != 1) begin n_err++; $display("FAIL single_beats: got %0d expected 1", beats); end
        n_vec++; if (s_valid !== 1'b0) begin n_err++; $display("FAIL single_idle: got %b expected 0", s_valid); end
    endtask

    task automatic test_random();
        int written = 0;
        for (int c = 0; c < 8000 && (written < 1000 || exp_q.size() != 0); c++) begin
            if (written < 1000 && wptr - rptr < 8 && $urandom_range(0, 1) == 1) begin
                push(written[7:0]);
                written++;
            end
            cycle(1'($urandom_range(0, 1)));
            n_vec++; if (s_ren && s_empty) begin n_err++; $display("FAIL rand_ren_empty: got ren=1 empty=1 expected ren=0"); end
            n_vec++; if (held > 2 || held < 0) begin n_err++; $display("FAIL rand_held: got %0d expected <=2", held); end
            n_vec++; if (s_cnt !== exp_cnt) begin n_err++; $display("FAIL rand_cnt: got %0d expected %0d", s_cnt, exp_cnt); end
            if (s_beat) begin
                n_vec++; if (s_bad || s_data !== s_exp) begin n_err++; $display("FAIL rand_data: got %h expected %h", s_data, s_exp); end
            end
        end
        n_vec++; if (written != 1000 || exp_q.size() != 0) begin n_err++; $display("FAIL rand_complete: got written=%0d left=%0d expected 1000 0", written, exp_q.size()); end
    endtask

    task automatic test_counter_wrap();
        int sent = 0, beats = 0;
        clr = 1;
        wptr = 0;
        model_clear();
        @(negedge clk);
        clr = 0;
        for (int c = 0; c < 100 && beats < 17; c++) begin
            if (sent < 17 && wptr - rptr < 8) begin
                push(8'hC0 + 8'(sent));
                sent++;
            end
            cycle(1);
            beats += int'(s_beat);
            n_vec++; if (s_cnt !== exp_cnt) begin n_err++; $display("FAIL wrap_cnt_step: got %0d expected %0d", s_cnt, exp_cnt); end
        end
        cycle(0);
`ifdef SYN_FIFO_READER_CNT_EN
        n_vec++; if (s_cnt !== 4'd1 || beats != 17) begin n_err++; $display("FAIL wrap_cnt: got cnt=%0d beats=%0d expected 1 17", s_cnt, beats); end
`else
        n_vec++; if (s_cnt !== 4'd0 || beats != 17) begin n_err++; $display("FAIL wrap_cnt: got cnt=%0d beats=%0d expected 0 17", s_cnt, beats); end
`endif
    endtask

    initial begin
        model_clear();
        test_reset();
        test_streaming();
        test_backpressure();
        test_empty_boundary();
        test_random();
        test_counter_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
